// File: rtl/gate_lane_scheduler.sv
// Shared barrier-gate scheduler for the entry/exit lanes: round-robin lane grant,
// motor open/hold/close sequencing and lot occupancy tracking.
module gate_lane_scheduler #(
    parameter int unsigned CAPACITY     = 16,
    parameter int unsigned OPEN_CYCLES  = 8,
    parameter int unsigned HOLD_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_entrada,
    input  logic             req_salida,
    input  logic             sensor_paso,
    output logic             grant_entrada,
    output logic             grant_salida,
    output logic             motor_abrir,
    output logic             motor_cerrar,
    output logic             lleno,
    output logic [CNT_W-1:0] ocupacion,
    output logic             alarma_timeout
);

    localparam int unsigned TMR_MAX = (HOLD_TIMEOUT > OPEN_CYCLES) ? HOLD_TIMEOUT : OPEN_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        StIdle,
        StOpening,
        StOpenWait,
        StClosing
    } state_e;

    state_e             state_q, state_d;
    logic               ptr_q, ptr_d;         // 0 = entrada next on a tie, 1 = salida
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               sensor_q, sensor_d;
    logic               grant_ent_q, grant_ent_d;
    logic               grant_sal_q, grant_sal_d;
    logic               abrir_q, abrir_d;
    logic               cerrar_q, cerrar_d;
    logic [CNT_W-1:0]   ocupacion_q, ocupacion_d;
    logic               alarma_q, alarma_d;

    logic valid_ent;
    logic valid_sal;
    logic pick_sal;
    logic pass_edge;

    assign lleno     = (ocupacion_q == CAP_VAL);
    assign valid_ent = req_entrada && !lleno;
    assign valid_sal = req_salida;
    assign pass_edge = sensor_paso && !sensor_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        timer_d     = timer_q + TMR_W'(1);
        sensor_d    = sensor_paso;
        grant_ent_d = grant_ent_q;
        grant_sal_d = grant_sal_q;
        ocupacion_d = ocupacion_q;
        alarma_d    = 1'b0;
        pick_sal    = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (valid_ent || valid_sal) begin
                    if (valid_ent && valid_sal) begin
                        pick_sal = ptr_q;
                        ptr_d    = !ptr_q;
                    end else begin
                        pick_sal = valid_sal;
                    end
                    grant_ent_d = !pick_sal;
                    grant_sal_d = pick_sal;
                    state_d     = StOpening;
                end
            end
            StOpening: begin
                if (timer_q == OPEN_LAST) begin
                    state_d = StOpenWait;
                    timer_d = '0;
                end
            end
            StOpenWait: begin
                // A pass on the final hold cycle wins over the timeout.
                if (pass_edge) begin
                    if (grant_ent_q && (ocupacion_q < CAP_VAL)) begin
                        ocupacion_d = ocupacion_q + CNT_W'(1);
                    end else if (grant_sal_q && (ocupacion_q != '0)) begin
                        ocupacion_d = ocupacion_q - CNT_W'(1);
                    end
                    state_d = StClosing;
                    timer_d = '0;
                end else if (timer_q == HOLD_LAST) begin
                    alarma_d = 1'b1;
                    state_d  = StClosing;
                    timer_d  = '0;
                end
            end
            StClosing: begin
                if (timer_q == OPEN_LAST) begin
                    state_d     = StIdle;
                    timer_d     = '0;
                    grant_ent_d = 1'b0;
                    grant_sal_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                timer_d     = '0;
                grant_ent_d = 1'b0;
                grant_sal_d = 1'b0;
            end
        endcase

        abrir_d  = (state_d == StOpening);
        cerrar_d = (state_d == StClosing);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            timer_q     <= '0;
            sensor_q    <= 1'b0;
            grant_ent_q <= 1'b0;
            grant_sal_q <= 1'b0;
            abrir_q     <= 1'b0;
            cerrar_q    <= 1'b0;
            ocupacion_q <= '0;
            alarma_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            sensor_q    <= sensor_d;
            grant_ent_q <= grant_ent_d;
            grant_sal_q <= grant_sal_d;
            abrir_q     <= abrir_d;
            cerrar_q    <= cerrar_d;
            ocupacion_q <= ocupacion_d;
            alarma_q    <= alarma_d;
        end
    end

    assign grant_entrada  = grant_ent_q;
    assign grant_salida   = grant_sal_q;
    assign motor_abrir    = abrir_q;
    assign motor_cerrar   = cerrar_q;
    assign ocupacion      = ocupacion_q;
    assign alarma_timeout = alarma_q;

endmodule

// File: tb/tb_gate_lane_scheduler.sv
// Directed bench for gate_lane_scheduler with a small lot (CAPACITY=2, OPEN_CYCLES=4,
// HOLD_TIMEOUT=10); expected values are hand-computed per scenario.
module tb_gate_lane_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_entrada = 1'b0;
    logic       req_salida = 1'b0;
    logic       sensor_paso = 1'b0;
    logic       grant_entrada;
    logic       grant_salida;
    logic       motor_abrir;
    logic       motor_cerrar;
    logic       lleno;
    logic [2:0] ocupacion;
    logic       alarma_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Cumulative activity counters, sampled on every rising edge.
    int n_abrir = 0;
    int n_cerrar = 0;
    int n_wait = 0;
    int n_alarm = 0;
    int n_viol = 0;

    gate_lane_scheduler #(
        .CAPACITY    (2),
        .OPEN_CYCLES (4),
        .HOLD_TIMEOUT(10),
        .CNT_W       (3)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_entrada   (req_entrada),
        .req_salida    (req_salida),
        .sensor_paso   (sensor_paso),
        .grant_entrada (grant_entrada),
        .grant_salida  (grant_salida),
        .motor_abrir   (motor_abrir),
        .motor_cerrar  (motor_cerrar),
        .lleno         (lleno),
        .ocupacion     (ocupacion),
        .alarma_timeout(alarma_timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (motor_abrir) n_abrir++;
        if (motor_cerrar) n_cerrar++;
        if (alarma_timeout) n_alarm++;
        if ((grant_entrada || grant_salida) && !motor_abrir && !motor_cerrar) n_wait++;
        if ((motor_abrir && motor_cerrar) || (grant_entrada && grant_salida)) n_viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_entrada = 1'b0;
        req_salida = 1'b0;
        sensor_paso = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // From a granted state, run until the gate is back in IDLE. With do_pass the sensor
    // rises on the second OPEN_WAIT cycle and stays high for 3 cycles.
    task automatic run_to_idle(input string tag, input bit do_pass);
        int ow = 0;
        int hold = 0;
        bit done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (!grant_entrada && !grant_salida) begin
                done = 1'b1;
                break;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) sensor_paso = 1'b0;
            end
            if (!motor_abrir && !motor_cerrar) begin
                ow++;
                if (do_pass && ow == 2) begin
                    sensor_paso = 1'b1;
                    hold = 3;
                end
            end
            tick();
        end
        sensor_paso = 1'b0;
        check_eq({tag, "_reach_idle"}, 32'(done), 32'd1);
    endtask

    // Full lane cycle: request for one edge, check next-cycle grant, run to IDLE and
    // compare motor/hold/alarm activity and the resulting occupancy.
    task automatic lane_cycle(input string tag, input bit entry, input bit do_pass,
                              input int exp_wait, input int exp_alarm, input int exp_occ);
        int s_ab = n_abrir;
        int s_ce = n_cerrar;
        int s_wt = n_wait;
        int s_al = n_alarm;
        if (entry) req_entrada = 1'b1;
        else req_salida = 1'b1;
        tick();
        req_entrada = 1'b0;
        req_salida = 1'b0;
        check_eq({tag, "_grant_ent"}, 32'(grant_entrada), 32'(entry));
        check_eq({tag, "_grant_sal"}, 32'(grant_salida), 32'(!entry));
        check_eq({tag, "_abrir_first"}, 32'(motor_abrir), 32'd1);
        run_to_idle(tag, do_pass);
        check_eq({tag, "_abrir_cycles"}, 32'(n_abrir - s_ab), 32'd4);
        check_eq({tag, "_cerrar_cycles"}, 32'(n_cerrar - s_ce), 32'd4);
        check_eq({tag, "_wait_cycles"}, 32'(n_wait - s_wt), 32'(exp_wait));
        check_eq({tag, "_alarm"}, 32'(n_alarm - s_al), 32'(exp_alarm));
        check_eq({tag, "_occ"}, 32'(ocupacion), 32'(exp_occ));
    endtask

    initial begin
        do_reset();
        check_eq("rst_grant_ent", 32'(grant_entrada), 32'd0);
        check_eq("rst_grant_sal", 32'(grant_salida), 32'd0);
        check_eq("rst_abrir", 32'(motor_abrir), 32'd0);
        check_eq("rst_cerrar", 32'(motor_cerrar), 32'd0);
        check_eq("rst_occ", 32'(ocupacion), 32'd0);
        check_eq("rst_lleno", 32'(lleno), 32'd0);
        check_eq("rst_alarm", 32'(alarma_timeout), 32'd0);

        // Single entry with a pass.
        lane_cycle("single_ent", 1'b1, 1'b1, 2, 0, 1);

        // Simultaneous requests: entrada first, then salida; next tie goes to salida.
        do_reset();
        req_entrada = 1'b1;
        req_salida = 1'b1;
        tick();
        check_eq("tie1_ent", 32'(grant_entrada), 32'd1);
        check_eq("tie1_sal", 32'(grant_salida), 32'd0);
        req_entrada = 1'b0;
        run_to_idle("tie1_a", 1'b1);
        check_eq("tie1_occ", 32'(ocupacion), 32'd1);
        tick();
        check_eq("tie1_sal_next", 32'(grant_salida), 32'd1);
        req_salida = 1'b0;
        run_to_idle("tie1_b", 1'b1);
        check_eq("tie1_occ_b", 32'(ocupacion), 32'd0);
        req_entrada = 1'b1;
        req_salida = 1'b1;
        tick();
        check_eq("tie2_sal", 32'(grant_salida), 32'd1);
        check_eq("tie2_ent", 32'(grant_entrada), 32'd0);
        req_salida = 1'b0;
        run_to_idle("tie2_a", 1'b1);
        tick();
        check_eq("tie2_ent_next", 32'(grant_entrada), 32'd1);
        req_entrada = 1'b0;
        run_to_idle("tie2_b", 1'b1);
        check_eq("tie2_occ", 32'(ocupacion), 32'd1);

        // Capacity: fill, refuse entry, free a space, then pending entry proceeds.
        do_reset();
        lane_cycle("cap_e1", 1'b1, 1'b1, 2, 0, 1);
        lane_cycle("cap_e2", 1'b1, 1'b1, 2, 0, 2);
        check_eq("cap_lleno", 32'(lleno), 32'd1);
        req_entrada = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("cap_refused", 32'(grant_entrada), 32'd0);
        check_eq("cap_no_motor", 32'(motor_abrir), 32'd0);
        req_salida = 1'b1;
        tick();
        check_eq("cap_sal_grant", 32'(grant_salida), 32'd1);
        check_eq("cap_ent_held", 32'(grant_entrada), 32'd0);
        req_salida = 1'b0;
        run_to_idle("cap_exit", 1'b1);
        check_eq("cap_occ_after_exit", 32'(ocupacion), 32'd1);
        check_eq("cap_lleno_after_exit", 32'(lleno), 32'd0);
        tick();
        check_eq("cap_pending_ent", 32'(grant_entrada), 32'd1);
        req_entrada = 1'b0;
        run_to_idle("cap_e3", 1'b1);
        check_eq("cap_occ_final", 32'(ocupacion), 32'd2);

        // Hold timeout: no pass, one alarm pulse, occupancy unchanged.
        do_reset();
        lane_cycle("timeout", 1'b1, 1'b0, 10, 1, 0);

        // Exit at empty lot: occupancy saturates at 0.
        do_reset();
        lane_cycle("exit_empty", 1'b0, 1'b1, 2, 0, 0);

        // Reset during the second OPENING cycle, with a vehicle already counted.
        do_reset();
        lane_cycle("pre_rst", 1'b1, 1'b1, 2, 0, 1);
        req_entrada = 1'b1;
        tick();
        req_entrada = 1'b0;
        tick();
        check_eq("mid_open_abrir", 32'(motor_abrir), 32'd1);
        reset = 1'b1;
        tick();
        check_eq("mrst_grant_ent", 32'(grant_entrada), 32'd0);
        check_eq("mrst_abrir", 32'(motor_abrir), 32'd0);
        check_eq("mrst_cerrar", 32'(motor_cerrar), 32'd0);
        check_eq("mrst_occ", 32'(ocupacion), 32'd0);
        reset = 1'b0;
        lane_cycle("post_rst", 1'b1, 1'b1, 2, 0, 1);

        check_eq("invariants", 32'(n_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
